context_seq: RTL and testbench

Command sequencer directly downstream of the command parser in the sys_clk domain. It captures each `context_en`/`context_cmd` strobe into a small queue. It replays the queued commands one at a time to the context-memory port over a req/ack handshake, with a timeout. Dropped commands and handshake timeouts are reported as sticky error flags.

---
 rtl/ctx_seq_pkg.sv | 25 ++
 rtl/ctx_seq_fifo.sv | 67 ++++++
 rtl/context_seq.sv | 130 +++++++++++++
 tb/tb_context_seq.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ctx_seq_pkg.sv
// Shared definitions for the context-memory command sequencer:
// FSM encodings, the NOP opcode and the context_cmd field layout.
package ctx_seq_pkg;

  localparam int unsigned CMD_W        = 8;
  localparam int unsigned CMD_ADDR_MSB = 7;
  localparam int unsigned CMD_ADDR_LSB = 4;
  localparam int unsigned CMD_OP_MSB   = 3;
  localparam int unsigned CMD_OP_LSB   = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

  localparam logic [3:0] CTX_OP_NOP = 4'h0;

  function automatic logic [3:0] cmd_addr(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
  endfunction

  function automatic logic [3:0] cmd_op(input logic [CMD_W-1:0] cmd);
    return cmd[CMD_OP_MSB:CMD_OP_LSB];
  endfunction

endpackage

// File: rtl/ctx_seq_fifo.sv
// DEPTH x CMD_W synchronous FIFO; a push into a full queue is accepted
// only when a pop happens in the same cycle.
module ctx_seq_fifo
  import ctx_seq_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [CMD_W-1:0]         push_data,
  input  logic                     pop,
  output logic [CMD_W-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic [$clog2(DEPTH):0]   level_nxt,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [CMD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop && (level_q != '0);
    do_push  = push && ((level_q < DEPTH_L) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    // Power-of-two depth: pointers wrap by natural overflow.
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head      = mem_q[rd_ptr_q];
  assign level     = level_q;
  assign level_nxt = level_d;
  assign full      = (level_q == DEPTH_L);
  assign empty     = (level_q == '0);

endmodule

// File: rtl/context_seq.sv
// Command sequencer: queues context_en/context_cmd strobes and replays them
// to the context-memory port over req/ack with a timeout and sticky errors.
module context_seq
  import ctx_seq_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   context_en,
  input  logic [7:0]             context_cmd,
  output logic                   ctx_req,
  output logic [3:0]             ctx_addr,
  output logic [3:0]             ctx_op,
  input  logic                   ctx_ack,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] q_level,
  output logic                   overflow,
  output logic                   timeout_err,
  input  logic                   err_clr
);

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  logic [1:0]             state_q, state_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [3:0]             addr_q, addr_d;
  logic [3:0]             op_q, op_d;
  logic                   req_q, req_d;
  logic                   busy_q, busy_d;
  logic                   ovf_q, ovf_d;
  logic                   tmo_q, tmo_d;

  logic                   pop;
  logic                   tmo_set;
  logic                   drop;
  logic [CMD_W-1:0]       head;
  logic [$clog2(DEPTH):0] level_nxt;
  logic                   fifo_full;
  logic                   fifo_empty;

  ctx_seq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (sys_clk),
    .rst_n     (sys_rst_n),
    .push      (context_en),
    .push_data (context_cmd),
    .pop       (pop),
    .head      (head),
    .level     (q_level),
    .level_nxt (level_nxt),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // Pop only happens on a non-empty queue, so full with no pop means a drop.
  assign drop = context_en && fifo_full && !pop;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    op_d    = op_q;
    req_d   = 1'b0;
    pop     = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop = 1'b1;
          if (cmd_op(head) != CTX_OP_NOP) begin
            addr_d  = cmd_addr(head);
            op_d    = cmd_op(head);
            cnt_d   = 8'd1;
            req_d   = 1'b1;
            state_d = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // cnt_q is the number of REQ cycles including the one being sampled.
        if (ctx_ack) begin
          state_d = ST_GAP;
        end else if (cnt_q == TMO) begin
          tmo_set = 1'b1;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
          req_d = 1'b1;
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) || (level_nxt != '0);
    ovf_d  = drop || (ovf_q && !err_clr);
    tmo_d  = tmo_set || (tmo_q && !err_clr);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      op_q    <= op_d;
      req_q   <= req_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      tmo_q   <= tmo_d;
    end
  end

  assign ctx_req     = req_q;
  assign ctx_addr    = addr_q;
  assign ctx_op      = op_q;
  assign busy        = busy_q;
  assign overflow    = ovf_q;
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_context_seq.sv
// Directed bench for context_seq (DEPTH=4, TIMEOUT=15) with hand-computed
// expectations for request timing, NOP skipping, overflow, timeout and reset.
module tb_context_seq;

  logic       sys_clk     = 1'b0;
  logic       sys_rst_n   = 1'b0;
  logic       context_en  = 1'b0;
  logic [7:0] context_cmd = '0;
  logic       ctx_ack     = 1'b0;
  logic       err_clr     = 1'b0;
  logic       ctx_req;
  logic [3:0] ctx_addr;
  logic [3:0] ctx_op;
  logic       busy;
  logic [2:0] q_level;
  logic       overflow;
  logic       timeout_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 sys_clk = ~sys_clk;

  context_seq #(.DEPTH(4), .TIMEOUT(15)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .context_en  (context_en),
    .context_cmd (context_cmd),
    .ctx_req     (ctx_req),
    .ctx_addr    (ctx_addr),
    .ctx_op      (ctx_op),
    .ctx_ack     (ctx_ack),
    .busy        (busy),
    .q_level     (q_level),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] c);
    context_en  = 1'b1;
    context_cmd = c;
  endtask

  logic [7:0]  ov_cmd [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  int unsigned ov_lvl [6] = '{1, 1, 2, 3, 4, 4};

  initial begin
    int unsigned n;
    logic        all_hi;

    // Reset values
    tick();
    tick();
    check("rst_req", ctx_req, 0);
    check("rst_addr", ctx_addr, 0);
    check("rst_op", ctx_op, 0);
    check("rst_busy", busy, 0);
    check("rst_lvl", q_level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_tmo", timeout_err, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    tick();

    // Single command, ack on the 3rd REQ cycle
    push(8'h35);
    tick();
    check("s_lvl1", q_level, 1);
    check("s_req_lo", ctx_req, 0);
    check("s_busy1", busy, 1);
    context_en = 1'b0;
    tick();
    check("s_req_hi", ctx_req, 1);
    check("s_addr", ctx_addr, 4'h3);
    check("s_op", ctx_op, 4'h5);
    check("s_lvl0", q_level, 0);
    tick();
    check("s_req_c2", ctx_req, 1);
    tick();
    check("s_req_c3", ctx_req, 1);
    ctx_ack = 1'b1;
    tick();
    ctx_ack = 1'b0;
    check("s_req_drop", ctx_req, 0);
    check("s_busy_gap", busy, 1);
    check("s_addr_hold", ctx_addr, 4'h3);
    tick();
    check("s_busy_idle", busy, 0);
    check("s_req_idle", ctx_req, 0);

    // Timeout then a normal issue; ack in the 15th cycle is a success
    push(8'h12);
    tick();
    push(8'h34);
    tick();
    context_en = 1'b0;
    check("t_req1", ctx_req, 1);
    check("t_addr1", ctx_addr, 4'h1);
    check("t_op1", ctx_op, 4'h2);
    n = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ctx_req) n++;
      else break;
    end
    check("t_req_cycles", n, 15);
    check("t_tmo_set", timeout_err, 1);
    tick();
    check("t_gap_req", ctx_req, 0);
    tick();
    check("t_req2", ctx_req, 1);
    check("t_addr2", ctx_addr, 4'h3);
    check("t_op2", ctx_op, 4'h4);
    check("t_tmo_held", timeout_err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("t_tmo_clr", timeout_err, 0);
    all_hi = 1'b1;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (!ctx_req) all_hi = 1'b0;
    end
    check("t_hold14", all_hi, 1);
    ctx_ack = 1'b1;
    tick();
    ctx_ack = 1'b0;
    check("t_ack15_req", ctx_req, 0);
    check("t_ack15_tmo", timeout_err, 0);
    tick();
    check("t_busy_end", busy, 0);

    // NOP skipping, with a stray ack held high while IDLE
    ctx_ack = 1'b1;
    push(8'h70);
    tick();
    check("n_req_a", ctx_req, 0);
    push(8'h80);
    tick();
    check("n_req_b", ctx_req, 0);
    check("n_lvl_b", q_level, 1);
    push(8'h92);
    tick();
    check("n_req_c", ctx_req, 0);
    check("n_lvl_c", q_level, 1);
    check("n_addr_kept", ctx_addr, 4'h3);
    context_en = 1'b0;
    ctx_ack    = 1'b0;
    tick();
    check("n_req_d", ctx_req, 1);
    check("n_addr", ctx_addr, 4'h9);
    check("n_op", ctx_op, 4'h2);
    check("n_lvl_d", q_level, 0);
    tick();
    check("n_req_hold", ctx_req, 1);
    ctx_ack = 1'b1;
    tick();
    ctx_ack = 1'b0;
    tick();
    check("n_busy_end", busy, 0);

    // Overflow with ack held low
    for (int i = 0; i < 6; i++) begin
      push(ov_cmd[i]);
      tick();
      check($sformatf("o_lvl%0d", i), q_level, ov_lvl[i]);
      check($sformatf("o_ovf%0d", i), overflow, (i == 5) ? 1 : 0);
    end
    check("o_req_addr", ctx_addr, 4'h1);
    context_en = 1'b0;
    err_clr    = 1'b1;
    tick();
    check("o_clr", overflow, 0);
    push(8'h77);
    tick();
    check("o_set_wins", overflow, 1);
    check("o_lvl_sat", q_level, 4);
    context_en = 1'b0;
    tick();
    err_clr = 1'b0;
    check("o_clr2", overflow, 0);

    // Full queue, IDLE pop with a simultaneous push
    ctx_ack = 1'b1;
    tick();
    ctx_ack = 1'b0;
    check("f_gap_req", ctx_req, 0);
    tick();
    check("f_idle_lvl", q_level, 4);
    push(8'hC7);
    tick();
    check("f_lvl", q_level, 4);
    check("f_ovf", overflow, 0);
    check("f_req", ctx_req, 1);
    check("f_addr", ctx_addr, 4'h2);
    push(8'hD8);
    tick();
    context_en = 1'b0;
    check("f_drop_ovf", overflow, 1);
    ctx_ack = 1'b1;
    tick();
    ctx_ack = 1'b0;
    tick();
    tick();
    check("r_req_pre", ctx_req, 1);
    check("r_lvl_pre", q_level, 3);
    check("r_addr_pre", ctx_addr, 4'h3);

    // Asynchronous reset mid-request
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("r_req", ctx_req, 0);
    check("r_lvl", q_level, 0);
    check("r_ovf", overflow, 0);
    check("r_tmo", timeout_err, 0);
    check("r_busy", busy, 0);
    #2;
    sys_rst_n = 1'b1;
    all_hi = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ctx_req || (q_level != 0) || busy) all_hi = 1'b1;
    end
    check("r_no_req_after", all_hi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1);
  end

endmodule
